// File: rtl/alu_pkg.sv
// Shared encodings for the ALU arbiter: ALU op codes, operand source select
// and the arbiter FSM states.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_MUL = 2'b10,
      ALU_NOT = 2'b11
   } alu_op_t;

   typedef enum logic {
      SRC_REG  = 1'b0,
      SRC_ADDR = 1'b1
   } alu_src_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Per-requester request/response channel between a front-end requester
// (master) and the ALU arbiter (slave).
interface alu_arbiter_if #(parameter int TAG_W = 4);

   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic [1:0]       req_op;
   logic             req_src;
   logic [15:0]      req_offset;
   logic [TAG_W-1:0] req_tag;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic             rsp_zero;
   logic [TAG_W-1:0] rsp_tag;

   modport master (
      output req_valid, req_a, req_b, req_op, req_src, req_offset, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_tag
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, req_src, req_offset, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_tag
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone valid requester wins outright, a tie
// goes to the requester that was not served last.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic       grant,
   output logic       any
);

   assign any   = |valid;
   assign grant = (&valid) ? ~last : valid[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between the execute stage (requester 0) and the
// load/store address generator (requester 1), one operation at a time.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_arbiter_if.slave     rq0,
   alu_arbiter_if.slave     rq1,
   output logic [31:0]      alu_in_1,
   output logic [31:0]      alu_in_2,
   output logic [1:0]       alu_op,
   output logic [15:0]      alu_offset,
   output logic             alu_source,
   input  logic [31:0]      alu_result,
   input  logic [31:0]      alu_result2,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   state_t           state;
   state_t           next_state;
   logic             accept;
   logic             capture;
   logic             complete;
   logic             grant;
   logic             grant_any;
   logic             owner;
   logic             last_served;
   logic [31:0]      iss_a;
   logic [31:0]      iss_b;
   alu_op_t          iss_op;
   alu_src_t         iss_src;
   logic [15:0]      iss_offset;
   logic [TAG_W-1:0] iss_tag;
   logic [31:0]      rsp_data;
   logic             rsp_zero;
   logic [TAG_W-1:0] rsp_tag;

   rr_arb2 u_arb (
      .valid ({rq1.req_valid, rq0.req_valid}),
      .last  (last_served),
      .grant (grant),
      .any   (grant_any)
   );

   assign rq0.req_ready = (state == IDLE) && grant_any && !grant;
   assign rq1.req_ready = (state == IDLE) && grant_any &&  grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      capture    = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (grant_any) begin
               accept     = 1'b1;
               next_state = EXEC;
            end
         end
         EXEC: begin
            capture    = 1'b1;
            next_state = RESP;
         end
         RESP: begin
            if (owner ? rq1.rsp_ready : rq0.rsp_ready) begin
               complete   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // The zero flag is derived here from the register path; the ALU's own flag is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner       <= 1'b0;
         last_served <= 1'b0;
         iss_a       <= '0;
         iss_b       <= '0;
         iss_op      <= ALU_ADD;
         iss_src     <= SRC_REG;
         iss_offset  <= '0;
         iss_tag     <= '0;
         rsp_data    <= '0;
         rsp_zero    <= 1'b0;
         rsp_tag     <= '0;
         op_count    <= '0;
      end else begin
         if (accept) begin
            owner       <= grant;
            last_served <= grant;
            iss_a       <= grant ? rq1.req_a      : rq0.req_a;
            iss_b       <= grant ? rq1.req_b      : rq0.req_b;
            iss_op      <= alu_op_t'(grant ? rq1.req_op : rq0.req_op);
            iss_src     <= alu_src_t'(grant ? rq1.req_src : rq0.req_src);
            iss_offset  <= grant ? rq1.req_offset : rq0.req_offset;
            iss_tag     <= grant ? rq1.req_tag    : rq0.req_tag;
         end
         if (capture) begin
            rsp_data <= (iss_src == SRC_ADDR) ? alu_result2 : alu_result;
            rsp_zero <= (iss_src == SRC_REG) && (alu_result == 32'd0);
            rsp_tag  <= iss_tag;
         end
         if (complete) op_count <= op_count + CNT_W'(1);
      end
   end

   assign alu_in_1   = iss_a;
   assign alu_in_2   = iss_b;
   assign alu_op     = iss_op;
   assign alu_offset = iss_offset;
   assign alu_source = iss_src;

   assign rq0.rsp_valid = (state == RESP) && !owner;
   assign rq1.rsp_valid = (state == RESP) &&  owner;
   assign rq0.rsp_data  = rsp_data;
   assign rq1.rsp_data  = rsp_data;
   assign rq0.rsp_zero  = rsp_zero;
   assign rq1.rsp_zero  = rsp_zero;
   assign rq0.rsp_tag   = rsp_tag;
   assign rq1.rsp_tag   = rsp_tag;

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table through a scoreboard,
// plus arbitration, backpressure, reset and counter-wrap sequences.
module tb_alu_arbiter;

   localparam int TAG_W = 4;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic             req;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [1:0]       op;
      logic             src;
      logic [15:0]      offset;
      logic [TAG_W-1:0] tag;
      logic [31:0]      exp_data;
      logic             exp_zero;
   } vec_t;

   typedef struct packed {
      logic [31:0]      data;
      logic             zero;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic [31:0]      alu_in_1;
   logic [31:0]      alu_in_2;
   logic [1:0]       alu_op;
   logic [15:0]      alu_offset;
   logic             alu_source;
   logic [31:0]      alu_result;
   logic [31:0]      alu_result2;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   alu_arbiter_if #(.TAG_W(TAG_W)) if0 ();
   alu_arbiter_if #(.TAG_W(TAG_W)) if1 ();

   alu_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rq0         (if0),
      .rq1         (if1),
      .alu_in_1    (alu_in_1),
      .alu_in_2    (alu_in_2),
      .alu_op      (alu_op),
      .alu_offset  (alu_offset),
      .alu_source  (alu_source),
      .alu_result  (alu_result),
      .alu_result2 (alu_result2),
      .busy        (busy),
      .op_count    (op_count)
   );

   // Stand-in for the external ALU that sits outside the arbiter
   always_comb begin
      case (alu_op)
         2'b00:   alu_result = alu_in_1 + alu_in_2;
         2'b01:   alu_result = alu_in_2 - alu_in_1;
         2'b10:   alu_result = alu_in_1 * alu_in_2;
         default: alu_result = ~alu_in_1;
      endcase
      alu_result2 = alu_in_1 + {16'h0000, alu_offset};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   check_count = 0;
   int   pass_count  = 0;
   int   both_ready_count = 0;
   exp_t sb_q0[$];
   exp_t sb_q1[$];
   vec_t vecs[10];
   logic [CNT_W-1:0] exp_count;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic checkResponse(input logic n);
      exp_t        e;
      int          depth;
      logic [31:0] d;
      logic        z;
      logic [TAG_W-1:0] t;
      depth = n ? sb_q1.size() : sb_q0.size();
      d = n ? if1.rsp_data : if0.rsp_data;
      z = n ? if1.rsp_zero : if0.rsp_zero;
      t = n ? if1.rsp_tag  : if0.rsp_tag;
      checkOutput($sformatf("rsp%0d_sb_depth", n), depth, 1);
      if (depth > 0) begin
         if (n) e = sb_q1.pop_front();
         else   e = sb_q0.pop_front();
         checkOutput($sformatf("rsp%0d_data", n), d, e.data);
         checkOutput($sformatf("rsp%0d_zero", n), {31'b0, z}, {31'b0, e.zero});
         checkOutput($sformatf("rsp%0d_tag", n), {28'b0, t}, {28'b0, e.tag});
      end
   endtask

   // Response monitor: every completed response handshake is scored
   always @(negedge clk) begin
      if (rst_n) begin
         if (if0.rsp_valid && if0.rsp_ready) checkResponse(1'b0);
         if (if1.rsp_valid && if1.rsp_ready) checkResponse(1'b1);
         if (if0.req_ready && if1.req_ready) both_ready_count++;
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic pushExpected(input vec_t v);
      exp_t e;
      e.data = v.exp_data;
      e.zero = v.exp_zero;
      e.tag  = v.tag;
      if (v.req) sb_q1.push_back(e);
      else       sb_q0.push_back(e);
   endtask

   task automatic driveReq(input vec_t v);
      if (v.req) begin
         if1.req_valid = 1'b1; if1.req_a = v.a; if1.req_b = v.b; if1.req_op = v.op;
         if1.req_src = v.src; if1.req_offset = v.offset; if1.req_tag = v.tag;
      end else begin
         if0.req_valid = 1'b1; if0.req_a = v.a; if0.req_b = v.b; if0.req_op = v.op;
         if0.req_src = v.src; if0.req_offset = v.offset; if0.req_tag = v.tag;
      end
   endtask

   // Waits for acceptance; returns at posedge+1 with the request withdrawn
   task automatic waitAccept(input vec_t v, input bit push, output int waited);
      logic rdy;
      rdy = 1'b0;
      waited = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         waited++;
         rdy = v.req ? if1.req_ready : if0.req_ready;
         if (rdy) break;
      end
      checkOutput($sformatf("req%0d_accept", v.req), {31'b0, rdy}, 32'd1);
      if (rdy && push) pushExpected(v);
      @(posedge clk);
      #1;
      if (v.req) if1.req_valid = 1'b0;
      else       if0.req_valid = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      int waited;
      @(posedge clk);
      #1;
      driveReq(v);
      waitAccept(v, 1'b1, waited);
   endtask

   function automatic logic rspValidOf(input logic n);
      return n ? if1.rsp_valid : if0.rsp_valid;
   endfunction

   task automatic runVector(input vec_t v, input string name);
      applyStimulus(v);
      @(negedge clk);
      checkOutput({name, "_exec_valid"}, {31'b0, rspValidOf(v.req)}, 32'd0);
      checkOutput({name, "_exec_busy"}, {31'b0, busy}, 32'd1);
      @(negedge clk);
      checkOutput({name, "_resp_valid"}, {31'b0, rspValidOf(v.req)}, 32'd1);
      exp_count++;
      @(negedge clk);
      checkOutput({name, "_op_count"}, {28'b0, op_count}, {28'b0, exp_count});
      checkOutput({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic checkResetState(input string pfx);
      checkOutput({pfx, "_busy"}, {31'b0, busy}, 32'd0);
      checkOutput({pfx, "_op_count"}, {28'b0, op_count}, 32'd0);
      checkOutput({pfx, "_rsp_valid"}, {30'b0, if1.rsp_valid, if0.rsp_valid}, 32'd0);
      checkOutput({pfx, "_req_ready"}, {30'b0, if1.req_ready, if0.req_ready}, 32'd0);
      checkOutput({pfx, "_rsp_data"}, if0.rsp_data, 32'd0);
      checkOutput({pfx, "_alu_in_1"}, alu_in_1, 32'd0);
      checkOutput({pfx, "_alu_ctl"}, {13'b0, alu_op, alu_source, alu_offset}, 32'd0);
   endtask

   task automatic resetDut();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      if0.req_valid = 1'b0;
      if1.req_valid = 1'b0;
      sb_q0.delete();
      sb_q1.delete();
      @(negedge clk);
      checkResetState("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_count = '0;
   endtask

   initial begin
      vec_t tie0, tie1;
      int   order[4];
      int   grants;
      int   waited;
      int   ready_hi;
      int   unstable;
      int   stray;
      logic [31:0] hold_data;
      logic [TAG_W-1:0] hold_tag;

      //           req   a             b             op     src   offset    tag    exp_data      zero
      vecs[0] = '{1'b0, 32'd5,        32'd7,        2'b00, 1'b0, 16'h0000, 4'd3,  32'd12,       1'b0};
      vecs[1] = '{1'b1, 32'd9,        32'd9,        2'b01, 1'b0, 16'h0000, 4'd5,  32'd0,        1'b1};
      vecs[2] = '{1'b1, 32'h0000_1000, 32'd0,       2'b00, 1'b1, 16'hFFFF, 4'd6,  32'h0001_0FFF, 1'b0};
      vecs[3] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 2'b10, 1'b0, 16'h0000, 4'd7, 32'd0,       1'b1};
      vecs[4] = '{1'b1, 32'd0,        32'h55,       2'b11, 1'b0, 16'h0000, 4'd8,  32'hFFFF_FFFF, 1'b0};
      vecs[5] = '{1'b0, 32'd3,        32'd10,       2'b01, 1'b0, 16'h0000, 4'd9,  32'd7,        1'b0};
      vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'd2,       2'b00, 1'b0, 16'h0000, 4'd10, 32'd1,        1'b0};
      vecs[7] = '{1'b1, 32'd7,        32'd6,        2'b10, 1'b0, 16'h0000, 4'd11, 32'd42,       1'b0};
      vecs[8] = '{1'b0, 32'hFFFF_FFF0, 32'h99,      2'b00, 1'b1, 16'h0020, 4'd12, 32'h0000_0010, 1'b0};
      vecs[9] = '{1'b1, 32'd0,        32'd0,        2'b00, 1'b1, 16'h0000, 4'd15, 32'd0,        1'b0};
      tie0    = '{1'b0, 32'd1,        32'd1,        2'b00, 1'b0, 16'h0000, 4'd1,  32'd2,        1'b0};
      tie1    = '{1'b1, 32'd2,        32'd3,        2'b00, 1'b0, 16'h0000, 4'd2,  32'd5,        1'b0};

      rst_n = 1'b0;
      exp_count = '0;
      if0.req_valid = 1'b0; if0.req_a = '0; if0.req_b = '0; if0.req_op = '0;
      if0.req_src = 1'b0; if0.req_offset = '0; if0.req_tag = '0; if0.rsp_ready = 1'b1;
      if1.req_valid = 1'b0; if1.req_a = '0; if1.req_b = '0; if1.req_op = '0;
      if1.req_src = 1'b0; if1.req_offset = '0; if1.req_tag = '0; if1.rsp_ready = 1'b1;

      // Tie arbitration straight out of reset: expected grant order 1,0,1,0
      resetDut();
      @(posedge clk);
      #1;
      driveReq(tie0);
      driveReq(tie1);
      grants = 0;
      for (int i = 0; i < 40 && grants < 4; i++) begin
         @(negedge clk);
         if (if0.req_ready) begin order[grants] = 0; grants++; pushExpected(tie0); end
         if (if1.req_ready) begin order[grants] = 1; grants++; pushExpected(tie1); end
      end
      @(posedge clk);
      #1;
      if0.req_valid = 1'b0;
      if1.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      exp_count = exp_count + CNT_W'(grants);
      checkOutput("tie_grants", grants, 4);
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("tie_order%0d", i), order[i], (i % 2 == 0) ? 1 : 0);
      checkOutput("tie_op_count", {28'b0, op_count}, 32'd4);

      // Table-driven single operations
      for (int i = 0; i < 10; i++) runVector(vecs[i], $sformatf("vec%0d", i));

      // Backpressure on requester 0 while requester 1 waits
      if0.rsp_ready = 1'b0;
      applyStimulus(vecs[5]);
      driveReq(vecs[7]);
      @(negedge clk);
      @(negedge clk);
      checkOutput("bp_rsp0_valid", {31'b0, if0.rsp_valid}, 32'd1);
      hold_data = if0.rsp_data;
      hold_tag  = if0.rsp_tag;
      ready_hi = 0;
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (if1.req_ready) ready_hi++;
         if (!if0.rsp_valid || if0.rsp_data !== hold_data || if0.rsp_tag !== hold_tag) unstable++;
      end
      checkOutput("bp_req1_ready_cycles", ready_hi, 0);
      checkOutput("bp_rsp0_unstable_cycles", unstable, 0);
      checkOutput("bp_op_count_held", {28'b0, op_count}, {28'b0, exp_count});
      @(posedge clk);
      #1;
      if0.rsp_ready = 1'b1;
      @(negedge clk);
      exp_count++;
      waitAccept(vecs[7], 1'b1, waited);
      checkOutput("bp_req1_accept_delay", waited, 1);
      repeat (3) @(negedge clk);
      exp_count++;
      checkOutput("bp_op_count", {28'b0, op_count}, {28'b0, exp_count});

      // Reset while an operation is in EXEC
      @(posedge clk);
      #1;
      driveReq(vecs[0]);
      waitAccept(vecs[0], 1'b0, waited);
      checkOutput("midexec_alu_in_1", alu_in_1, vecs[0].a);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetState("midexec");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_count = '0;
      stray = 0;
      repeat (4) begin
         @(negedge clk);
         if (if0.rsp_valid || if1.rsp_valid) stray++;
      end
      checkOutput("midexec_no_response", stray, 0);
      runVector(vecs[2], "post_reset");

      // Counter wrap: drive the counter through its full range
      resetDut();
      for (int i = 0; i < (1 << CNT_W); i++) runVector(vecs[0], $sformatf("wrap%0d", i));
      checkOutput("wrap_op_count", {28'b0, op_count}, 32'd0);

      checkOutput("both_ready_cycles", both_ready_count, 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
